// File: rtl/bnn_pkg.sv
// Shared definitions for the binarized-vector producer and the XNOR-popcount consumers.
// Holds default geometry, the FSM encoding, the bit-order mapping and the binarize rule.
package bnn_pkg;

    localparam int VEC_W_DEF  = 256;
    localparam int LANES_DEF  = 16;
    localparam int ACT_W_DEF  = 8;
    localparam int BEATS      = VEC_W_DEF / LANES_DEF;
    localparam int BEAT_CNT_W = $clog2(BEATS);

    // Activations and thresholds are sign-extended to this width before comparison.
    localparam int ACT_EXT_W  = 32;

    typedef enum logic [0:0] {
        ST_FILL      = 1'b0,
        ST_HOLD_FULL = 1'b1
    } pack_state_e;

    // Vector bit position of (beat, lane); the popcount layers use the same order.
    function automatic int vec_bit_idx(input int beat, input int lane, input int lanes);
        return beat * lanes + lane;
    endfunction

    function automatic logic binarize(input logic signed [ACT_EXT_W-1:0] act,
                                      input logic signed [ACT_EXT_W-1:0] thresh);
        return (act >= thresh);
    endfunction

endpackage

// File: rtl/bnn_act_packer_binarizer.sv
// LANES parallel comparators turning one beat of signed activations into LANES bits.
// With BNN_PACK_THRESH_EN defined each lane compares against thresh_i, otherwise against zero.
module bnn_lane_binarizer
    import bnn_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int ACT_W = ACT_W_DEF
) (
    input  logic [LANES*ACT_W-1:0] data_i,
`ifdef BNN_PACK_THRESH_EN
    input  logic [ACT_W-1:0]       thresh_i,
`endif
    output logic [LANES-1:0]       bits_o
);

    logic signed [ACT_EXT_W-1:0] thr_ext_s;

    // Per-lane signed compare against the (optional) threshold.
    always_comb begin
`ifdef BNN_PACK_THRESH_EN
        thr_ext_s = ACT_EXT_W'($signed(thresh_i));
`else
        thr_ext_s = '0;
`endif
        bits_o = '0;
        for (int i = 0; i < LANES; i++) begin
            bits_o[i] = binarize(ACT_EXT_W'($signed(data_i[i*ACT_W +: ACT_W])), thr_ext_s);
        end
    end

endmodule

// File: rtl/bnn_act_packer.sv
// Packs binarized activation beats into VEC_W-bit vectors with a valid/ready output.
// Optional per-beat signed threshold input enabled by BNN_PACK_THRESH_EN.
module bnn_act_packer
    import bnn_pkg::*;
#(
    parameter  int VEC_W  = VEC_W_DEF,
    parameter  int LANES  = LANES_DEF,
    parameter  int ACT_W  = ACT_W_DEF,
    localparam int NBEATS = VEC_W / LANES,
    localparam int CNT_W  = $clog2(NBEATS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*ACT_W-1:0] in_data,
    input  logic                   in_last,
`ifdef BNN_PACK_THRESH_EN
    input  logic [ACT_W-1:0]       thresh,
`endif
    output logic [VEC_W-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   short_err,
    output logic [CNT_W-1:0]       beat_cnt
);

    pack_state_e      state_q, state_d;
    logic [VEC_W-1:0] acc_q, acc_d;
    logic [VEC_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             short_err_q, short_err_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [LANES-1:0] lane_bits_s;
    logic [VEC_W-1:0] acc_ins_s;
    logic             last_beat_s;
    logic             closing_s;
    logic             out_free_s;
    logic             accept_s;

    bnn_lane_binarizer #(
        .LANES (LANES),
        .ACT_W (ACT_W)
    ) u_binarizer (
        .data_i   (in_data),
`ifdef BNN_PACK_THRESH_EN
        .thresh_i (thresh),
`endif
        .bits_o   (lane_bits_s)
    );

    assign last_beat_s = (beat_cnt_q == CNT_W'(NBEATS - 1));
    assign closing_s   = last_beat_s || in_last;
    assign out_free_s  = !out_valid_q || out_ready;
    assign accept_s    = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a closing beat that finds the output register busy parks in HOLD_FULL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (in_valid && closing_s && !out_free_s) begin
                    state_d = ST_HOLD_FULL;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_HOLD_FULL: begin
                if (out_ready) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_HOLD_FULL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Output decode: only a closing beat can be stalled, and only by a held vector.
    always_comb begin
        in_ready = 1'b1;
        case (state_q)
            ST_FILL:      in_ready = !closing_s || out_free_s;
            ST_HOLD_FULL: in_ready = !closing_s || out_ready;
            default:      in_ready = 1'b1;
        endcase
    end

    // Datapath next-state: insert the beat, and on a closing beat hand acc to the output.
    always_comb begin
        acc_ins_s = acc_q;
        acc_ins_s[vec_bit_idx(int'(beat_cnt_q), 0, LANES) +: LANES] = lane_bits_s;

        acc_d       = acc_q;
        out_data_d  = out_data_q;
        beat_cnt_d  = beat_cnt_q;
        short_err_d = 1'b0;

        if (accept_s && closing_s) begin
            acc_d       = '0;
            out_data_d  = acc_ins_s;
            beat_cnt_d  = '0;
            short_err_d = !last_beat_s;
        end else if (accept_s) begin
            acc_d      = acc_ins_s;
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end else begin
            acc_d      = acc_q;
            beat_cnt_d = beat_cnt_q;
        end

        if (accept_s && closing_s) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Datapath registers; reset discards any partial vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            short_err_q <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            short_err_q <= short_err_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign short_err = short_err_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_bnn_act_packer.sv
// Self-checking bench for bnn_act_packer: random activations against a per-lane reference model.
module tb_bnn_act_packer;

    localparam int VEC_W = 256;
    localparam int LANES = 16;
    localparam int ACT_W = 8;
    localparam int NB    = VEC_W / LANES;
    localparam int CNT_W = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*ACT_W-1:0] in_data;
    logic                   in_last;
    logic [VEC_W-1:0]       out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   short_err;
    logic [CNT_W-1:0]       beat_cnt;
    logic signed [ACT_W-1:0] thr;
`ifdef BNN_PACK_THRESH_EN
    logic [ACT_W-1:0]       thresh;
    assign thresh = thr;
`endif

    int checks = 0;
    int errors = 0;

    logic signed [ACT_W-1:0] mdl [NB][LANES];
    logic [VEC_W-1:0]        expq[$];

    always #5 clk = ~clk;

    bnn_act_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
`ifdef BNN_PACK_THRESH_EN
        .thresh    (thresh),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .short_err (short_err),
        .beat_cnt  (beat_cnt)
    );

    // Reference: lane i of beat k is 1 when its activation is >= threshold; unsent beats are 0.
    function automatic logic [VEC_W-1:0] ref_vec(input int nb);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int k = 0; k < nb; k++)
            for (int i = 0; i < LANES; i++)
                if (mdl[k][i] >= thr) v[k*LANES + i] = 1'b1;
        return v;
    endfunction

    function automatic logic [LANES*ACT_W-1:0] pack_beat(input int k);
        logic [LANES*ACT_W-1:0] d;
        d = '0;
        for (int i = 0; i < LANES; i++) d[i*ACT_W +: ACT_W] = mdl[k][i];
        return d;
    endfunction

    task automatic set_beat_rand(input int k);
        for (int i = 0; i < LANES; i++) begin
            if ($urandom_range(0, 7) == 0) mdl[k][i] = 8'sd0;
            else                           mdl[k][i] = ACT_W'($urandom_range(0, 255));
        end
    endtask

    task automatic set_beat_const(input int k, input logic signed [ACT_W-1:0] val);
        for (int i = 0; i < LANES; i++) mdl[k][i] = val;
    endtask

    // Present beat k for one clock; acc reports whether it was accepted.
    task automatic beat_cycle(input int k, input logic last, output logic acc);
        in_valid = 1'b1;
        in_data  = pack_beat(k);
        in_last  = last;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (short_err !== 1'b0) begin errors++; $display("FAIL reset_short_err: got %b expected 0", short_err); end
        checks++; if (beat_cnt !== 4'd0) begin errors++; $display("FAIL reset_beat_cnt: got %0d expected 0", beat_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst_n = 1'b1;
        idle_cycle();
    endtask

    task automatic test_full_vector();
        logic acc;
        out_ready = 1'b1;
        for (int k = 0; k < NB; k++) begin
            set_beat_const(k, 8'sd5);
            beat_cycle(k, 1'b0, acc);
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL full_accept: beat %0d in_ready %b expected 1", k, acc); end
            if (k < NB - 1) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid: beat %0d got %b expected 0", k, out_valid); end
                checks++; if (beat_cnt !== CNT_W'(k + 1)) begin errors++; $display("FAIL full_beat_cnt: got %0d expected %0d", beat_cnt, k + 1); end
            end
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== ref_vec(NB)) begin errors++; $display("FAIL full_data: got %h expected %h", out_data, ref_vec(NB)); end
        checks++; if (short_err !== 1'b0) begin errors++; $display("FAIL full_short_err: got %b expected 0", short_err); end
        checks++; if (beat_cnt !== 4'd0) begin errors++; $display("FAIL full_cnt_clear: got %0d expected 0", beat_cnt); end
        idle_cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_valid_fall: got %b expected 0", out_valid); end
    endtask

    task automatic test_bit_order();
        logic acc;
        logic [VEC_W-1:0] expc;
        out_ready = 1'b1;
        for (int k = 0; k < NB; k++) set_beat_const(k, 8'sd0);
        mdl[0][0]   = -8'sd1;
        mdl[15][15] = -8'sd128;
        for (int k = 0; k < NB; k++) beat_cycle(k, 1'b0, acc);
        expc = '1;
        expc[0] = 1'b0;
        expc[VEC_W-1] = 1'b0;
        if (thr == 8'sd0) begin
            checks++; if (out_data !== expc) begin errors++; $display("FAIL bit_order_const: got %h expected %h", out_data, expc); end
        end
        checks++; if (out_data !== ref_vec(NB)) begin errors++; $display("FAIL bit_order_ref: got %h expected %h", out_data, ref_vec(NB)); end
        idle_cycle();
    endtask

    task automatic test_random_gaps();
        logic acc;
        logic last;
        int   gaps;
        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            for (int k = 0; k < NB; k++) begin
                set_beat_rand(k);
                last = (k == NB - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                beat_cycle(k, last, acc);
                checks++; if (acc !== 1'b1) begin errors++; $display("FAIL gaps_accept: beat %0d in_ready %b expected 1", k, acc); end
                gaps = (k < NB - 1) ? $urandom_range(0, 2) : 0;
                for (int g = 0; g < gaps; g++) begin
                    idle_cycle();
                    checks++; if (beat_cnt !== CNT_W'(k + 1)) begin errors++; $display("FAIL gaps_cnt_hold: got %0d expected %0d", beat_cnt, k + 1); end
                end
            end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gaps_valid: got %b expected 1", out_valid); end
            checks++; if (out_data !== ref_vec(NB)) begin errors++; $display("FAIL gaps_data: got %h expected %h", out_data, ref_vec(NB)); end
            checks++; if (short_err !== 1'b0) begin errors++; $display("FAIL gaps_short_err: got %b expected 0", short_err); end
            idle_cycle();
        end
    endtask

    task automatic test_early_last();
        logic acc;
        int   len;
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            len = (v == 0) ? 3 : $urandom_range(1, NB - 1);
            for (int k = 0; k < len; k++) begin
                if (v == 0) set_beat_const(k, 8'sd1);
                else        set_beat_rand(k);
                beat_cycle(k, (k == len - 1), acc);
            end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL early_valid: len %0d got %b expected 1", len, out_valid); end
            checks++; if (short_err !== 1'b1) begin errors++; $display("FAIL early_short_err: len %0d got %b expected 1", len, short_err); end
            checks++; if (out_data !== ref_vec(len)) begin errors++; $display("FAIL early_data: len %0d got %h expected %h", len, out_data, ref_vec(len)); end
            checks++; if (beat_cnt !== 4'd0) begin errors++; $display("FAIL early_cnt: got %0d expected 0", beat_cnt); end
            idle_cycle();
            checks++; if (short_err !== 1'b0) begin errors++; $display("FAIL early_pulse_width: got %b expected 0", short_err); end
        end
    endtask

    task automatic test_backpressure();
        logic acc;
        logic [VEC_W-1:0] exp_a;
        logic [VEC_W-1:0] exp_b;
        out_ready = 1'b1;
        for (int k = 0; k < NB; k++) begin
            set_beat_rand(k);
            beat_cycle(k, 1'b0, acc);
        end
        exp_a = ref_vec(NB);
        out_ready = 1'b0;
        for (int k = 0; k < NB - 1; k++) begin
            set_beat_rand(k);
            beat_cycle(k, 1'b0, acc);
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL bp_accept: beat %0d in_ready %b expected 1", k, acc); end
            checks++; if (out_data !== exp_a || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_a: got %h valid %b expected %h valid 1", out_data, out_valid, exp_a); end
        end
        set_beat_rand(NB - 1);
        exp_b = ref_vec(NB);
        in_valid = 1'b1;
        in_data  = pack_beat(NB - 1);
        in_last  = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: in_ready %b expected 0", in_ready); end
        @(posedge clk);
        #1;
        checks++; if (out_data !== exp_a) begin errors++; $display("FAIL bp_still_a: got %h expected %h", out_data, exp_a); end
        checks++; if (beat_cnt !== 4'd15) begin errors++; $display("FAIL bp_cnt_hold: got %0d expected 15", beat_cnt); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: in_ready %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_b_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== exp_b) begin errors++; $display("FAIL bp_b_data: got %h expected %h", out_data, exp_b); end
        checks++; if (beat_cnt !== 4'd0) begin errors++; $display("FAIL bp_b_cnt: got %0d expected 0", beat_cnt); end
        idle_cycle();
        checks++; if (out_valid !== 1'b1 || out_data !== exp_b) begin errors++; $display("FAIL bp_b_held: got %h valid %b expected %h valid 1", out_data, out_valid, exp_b); end
        out_ready = 1'b1;
        idle_cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_b_consumed: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic acc;
        int   nvalid = 0;
        int   nready = 0;
        logic [VEC_W-1:0] exp_v;
        out_ready = 1'b1;
        expq.delete();
        for (int n = 0; n <= 4 * NB; n++) begin
            if (n < 4 * NB) begin
                set_beat_rand(n % NB);
                if (n % NB == NB - 1) expq.push_back(ref_vec(NB));
                beat_cycle(n % NB, 1'b0, acc);
                if (acc === 1'b1) nready++;
            end else begin
                idle_cycle();
            end
            if (out_valid === 1'b1) begin
                nvalid++;
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b2b_unexpected: out_valid at step %0d with no vector pending", n);
                end else begin
                    exp_v = expq.pop_front();
                    checks++; if (out_data !== exp_v) begin errors++; $display("FAIL b2b_data: got %h expected %h", out_data, exp_v); end
                end
            end
        end
        checks++; if (nready !== 4 * NB) begin errors++; $display("FAIL b2b_ready: got %0d accepted expected %0d", nready, 4 * NB); end
        checks++; if (nvalid !== 4) begin errors++; $display("FAIL b2b_valid_cycles: got %0d expected 4", nvalid); end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        logic acc;
        out_ready = 1'b0;
        for (int k = 0; k < NB; k++) begin
            set_beat_rand(k);
            beat_cycle(k, 1'b0, acc);
        end
        for (int k = 0; k < 7; k++) begin
            set_beat_const(k, 8'sd100);
            beat_cycle(k, 1'b0, acc);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
        checks++; if (beat_cnt !== 4'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d expected 0", beat_cnt); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rstmid_data: got %h expected 0", out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_beat_const(k, -8'sd7);
            beat_cycle(k, (k == 2), acc);
        end
        checks++; if (out_data !== ref_vec(3)) begin errors++; $display("FAIL rstmid_short: got %h expected %h", out_data, ref_vec(3)); end
        idle_cycle();
        for (int k = 0; k < NB; k++) begin
            set_beat_rand(k);
            beat_cycle(k, 1'b0, acc);
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_fresh_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== ref_vec(NB)) begin errors++; $display("FAIL rstmid_fresh: got %h expected %h", out_data, ref_vec(NB)); end
        idle_cycle();
    endtask

`ifdef BNN_PACK_THRESH_EN
    task automatic test_thresh();
        logic acc;
        out_ready = 1'b1;
        thr = 8'sd3;
        for (int k = 0; k < NB; k++) begin
            for (int i = 0; i < LANES; i++) mdl[k][i] = (i % 2 == 0) ? 8'sd3 : 8'sd2;
            if (k == 5) set_beat_rand(k);
            beat_cycle(k, 1'b0, acc);
        end
        checks++; if (out_data[0] !== 1'b1 || out_data[1] !== 1'b0) begin errors++; $display("FAIL thresh_edge: got bits %b%b expected 01", out_data[1], out_data[0]); end
        checks++; if (out_data !== ref_vec(NB)) begin errors++; $display("FAIL thresh_data: got %h expected %h", out_data, ref_vec(NB)); end
        idle_cycle();
        thr = 8'sd0;
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        thr       = 8'sd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_full_vector();
        test_bit_order();
        test_random_gaps();
        test_early_last();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef BNN_PACK_THRESH_EN
        test_thresh();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
